// File: rtl/pipelined_execute_unit_if.sv
// Decode-to-memory handshake bundle for the pipelined execute stage.
// The master side is the upstream/downstream pipeline; the slave side is the execute unit.
interface pipelined_execute_unit_if #(
    parameter int XLEN = 32,
    parameter int WB_W = 14
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            b_src;
    logic            adr_a_pc;
    logic            is_branch;
    logic            is_jump;
    logic            is_auipc;
    logic            is_lui;
    logic            is_muldiv;
    logic [WB_W-1:0] wb_ctrl_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] calc_adr;
    logic [XLEN-1:0] rs2_out;
    logic            branch_taken;
    logic [2:0]      funct3_out;
    logic [WB_W-1:0] wb_ctrl_out;
    logic            busy;

    modport master (
        output flush, in_valid, pc, pc_plus_4, imm, rs1_val, rs2_val, funct3, funct7,
               b_src, adr_a_pc, is_branch, is_jump, is_auipc, is_lui, is_muldiv,
               wb_ctrl_in, out_ready,
        input  in_ready, out_valid, result, calc_adr, rs2_out, branch_taken,
               funct3_out, wb_ctrl_out, busy
    );

    modport slave (
        input  flush, in_valid, pc, pc_plus_4, imm, rs1_val, rs2_val, funct3, funct7,
               b_src, adr_a_pc, is_branch, is_jump, is_auipc, is_lui, is_muldiv,
               wb_ctrl_in, out_ready,
        output in_ready, out_valid, result, calc_adr, rs2_out, branch_taken,
               funct3_out, wb_ctrl_out, busy
    );
endinterface

// File: rtl/pipelined_execute_unit.sv
// Registered execute stage: 1-cycle ALU/branch/jump/AUIPC/LUI path plus an
// iterative shift-add multiplier and restoring divider behind valid/ready.
module pipelined_execute_unit #(
    parameter int XLEN      = 32,
    parameter int WB_W      = 14,
    parameter int MULDIV_EN = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_execute_unit_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic            out_valid_q;
    logic            busy_q;
    logic            taken_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] calc_q;
    logic [XLEN-1:0] rs2_q;
    logic [2:0]      f3_out_q;
    logic [WB_W-1:0] wb_out_q;

    logic [2:0]        md_f3;
    logic [WB_W-1:0]   md_wb;
    logic [XLEN-1:0]   md_a;
    logic [XLEN-1:0]   md_b;
    logic              md_neg;
    logic              md_rneg;
    logic              md_dz;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvsr;

    logic              out_free;
    logic              in_ready_c;
    logic              accept;
    logic              is_md;
    logic [XLEN-1:0]   op_b;
    logic [SW-1:0]     shamt;
    logic [XLEN-1:0]   adr_sum;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   fwd_res;
    logic              cond;
    logic              sgn_a;
    logic              sgn_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     r_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   md_res;

    assign out_free   = !out_valid_q || bus.out_ready;
    assign in_ready_c = rst_n && (state == IDLE) && out_free && !bus.flush;
    assign accept     = bus.in_valid && in_ready_c;
    assign is_md      = (MULDIV_EN != 0) && bus.is_muldiv;

    always_comb begin
        op_b    = bus.b_src ? bus.imm : bus.rs2_val;
        shamt   = op_b[SW-1:0];
        adr_sum = (bus.adr_a_pc ? bus.pc : bus.rs1_val) + bus.imm;

        alu_res = '0;
        case (bus.funct3)
            3'b000: alu_res = bus.funct7[5] ? bus.rs1_val - op_b : bus.rs1_val + op_b;
            3'b001: alu_res = bus.rs1_val << shamt;
            3'b010: alu_res[0] = $signed(bus.rs1_val) < $signed(op_b);
            3'b011: alu_res[0] = bus.rs1_val < op_b;
            3'b100: alu_res = bus.rs1_val ^ op_b;
            3'b101: alu_res = bus.funct7[5] ? $unsigned($signed(bus.rs1_val) >>> shamt)
                                            : bus.rs1_val >> shamt;
            3'b110: alu_res = bus.rs1_val | op_b;
            default: alu_res = bus.rs1_val & op_b;
        endcase

        case (bus.funct3)
            3'b000:  cond = bus.rs1_val == bus.rs2_val;
            3'b001:  cond = bus.rs1_val != bus.rs2_val;
            3'b100:  cond = $signed(bus.rs1_val) <  $signed(bus.rs2_val);
            3'b101:  cond = $signed(bus.rs1_val) >= $signed(bus.rs2_val);
            3'b110:  cond = bus.rs1_val <  bus.rs2_val;
            3'b111:  cond = bus.rs1_val >= bus.rs2_val;
            default: cond = 1'b0;
        endcase

        if (bus.is_jump)       fwd_res = bus.pc_plus_4;
        else if (bus.is_auipc) fwd_res = adr_sum;
        else if (bus.is_lui)   fwd_res = bus.imm;
        else                   fwd_res = alu_res;
    end

    // Operand signedness: MULHU and the unsigned divides take magnitudes as-is;
    // MULHSU treats only rs1 as signed.
    always_comb begin
        sgn_a = bus.rs1_val[XLEN-1] & (bus.funct3[2] ? !bus.funct3[0] : (bus.funct3[1:0] != 2'b11));
        sgn_b = bus.rs2_val[XLEN-1] & (bus.funct3[2] ? !bus.funct3[0] : !bus.funct3[1]);
        mag_a = sgn_a ? -bus.rs1_val : bus.rs1_val;
        mag_b = sgn_b ? -bus.rs2_val : bus.rs2_val;

        r_sh     = {rem, quo[XLEN-1]};
        diff     = r_sh - {1'b0, dvsr};
        prod_fix = md_neg ? -prod : prod;

        md_res = '0;
        if (!md_f3[2]) begin
            md_res = (md_f3[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!md_f3[1]) begin
            md_res = md_dz ? '1 : (md_neg ? -quo : quo);
        end else begin
            md_res = md_dz ? md_a : (md_rneg ? -rem : rem);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            taken_q     <= 1'b0;
            result_q    <= '0;
            calc_q      <= '0;
            rs2_q       <= '0;
            f3_out_q    <= '0;
            wb_out_q    <= '0;
            md_f3       <= '0;
            md_wb       <= '0;
            md_a        <= '0;
            md_b        <= '0;
            md_neg      <= 1'b0;
            md_rneg     <= 1'b0;
            md_dz       <= 1'b0;
            mcand       <= '0;
            prod        <= '0;
            mplier      <= '0;
            quo         <= '0;
            rem         <= '0;
            dvsr        <= '0;
        end else if (bus.flush) begin
            state       <= IDLE;
            cnt         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // A consumed result drops valid unless a load below refills the register.
            if (bus.out_ready) out_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && is_md) begin
                        md_f3   <= bus.funct3;
                        md_wb   <= bus.wb_ctrl_in;
                        md_a    <= bus.rs1_val;
                        md_b    <= bus.rs2_val;
                        md_neg  <= sgn_a ^ sgn_b;
                        md_rneg <= sgn_a;
                        md_dz   <= bus.rs2_val == '0;
                        mcand   <= {{XLEN{1'b0}}, mag_a};
                        mplier  <= mag_b;
                        prod    <= '0;
                        quo     <= mag_a;
                        rem     <= '0;
                        dvsr    <= mag_b;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= bus.funct3[2] ? DIV : MUL;
                    end else if (accept) begin
                        result_q    <= fwd_res;
                        calc_q      <= adr_sum;
                        rs2_q       <= bus.rs2_val;
                        taken_q     <= bus.is_branch & cond;
                        f3_out_q    <= bus.funct3;
                        wb_out_q    <= bus.wb_ctrl_in;
                        out_valid_q <= 1'b1;
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == CW'(XLEN - 1)) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DIV: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= r_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    if (cnt == CW'(XLEN - 1)) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_free) begin
                        result_q    <= md_res;
                        calc_q      <= '0;
                        rs2_q       <= md_b;
                        taken_q     <= 1'b0;
                        f3_out_q    <= md_f3;
                        wb_out_q    <= md_wb;
                        out_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.calc_adr     = calc_q;
    assign bus.rs2_out      = rs2_q;
    assign bus.branch_taken = taken_q;
    assign bus.funct3_out   = f3_out_q;
    assign bus.wb_ctrl_out  = wb_out_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_pipelined_execute_unit.sv
// Self-checking bench: directed corner cases plus randomized ops with random
// output backpressure, scored against a plain-arithmetic reference model.
module tb_pipelined_execute_unit;
    localparam int XLEN = 32;
    localparam int WB_W = 14;

    typedef struct {
        logic [31:0] pc, imm, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        b_src, adr_pc, br, jmp, auipc, lui, md;
        logic [13:0] wb;
    } op_t;

    typedef struct {
        logic [31:0] result, calc, rs2;
        logic        taken, md;
        logic [2:0]  f3;
        logic [13:0] wb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bp_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [31:0] last_res, last_calc;
    logic        last_taken;

    pipelined_execute_unit_if #(.XLEN(XLEN), .WB_W(WB_W)) bus();

    pipelined_execute_unit #(.XLEN(XLEN), .WB_W(WB_W), .MULDIV_EN(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input op_t op);
        exp_t e;
        logic [31:0] a, b, bo, alu;
        logic signed [63:0] p;
        logic [63:0] pu;
        logic c;
        int sh;
        a = op.rs1; b = op.rs2; bo = op.b_src ? op.imm : op.rs2;
        sh = int'(bo[4:0]);
        case (op.f3)
            3'd0: alu = op.f7[5] ? a - bo : a + bo;
            3'd1: alu = a << sh;
            3'd2: alu = (int'(a) < int'(bo)) ? 32'd1 : 32'd0;
            3'd3: alu = (a < bo) ? 32'd1 : 32'd0;
            3'd4: alu = a ^ bo;
            3'd5: alu = op.f7[5] ? 32'(int'(a) >>> sh) : a >> sh;
            3'd6: alu = a | bo;
            default: alu = a & bo;
        endcase
        case (op.f3)
            3'd0: c = a == b;
            3'd1: c = a != b;
            3'd4: c = int'(a) < int'(b);
            3'd5: c = int'(a) >= int'(b);
            3'd6: c = a < b;
            3'd7: c = a >= b;
            default: c = 1'b0;
        endcase
        e.calc = (op.adr_pc ? op.pc : a) + op.imm;
        e.rs2 = b; e.f3 = op.f3; e.wb = op.wb; e.md = op.md;
        e.taken = op.br & c;
        if (op.jmp)        e.result = op.pc + 32'd4;
        else if (op.auipc) e.result = e.calc;
        else if (op.lui)   e.result = op.imm;
        else               e.result = alu;
        if (op.md) begin
            case (op.f3)
                3'd0: begin p = longint'(int'(a)) * longint'(int'(b)); e.result = p[31:0]; end
                3'd1: begin p = longint'(int'(a)) * longint'(int'(b)); e.result = p[63:32]; end
                3'd2: begin p = longint'(int'(a)) * longint'({32'd0, b}); e.result = p[63:32]; end
                3'd3: begin pu = {32'd0, a} * {32'd0, b}; e.result = pu[63:32]; end
                3'd4: e.result = (b == 0) ? 32'hFFFF_FFFF :
                                 (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(int'(a) / int'(b));
                3'd5: e.result = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: e.result = (b == 0) ? a :
                                 (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(int'(a) % int'(b));
                default: e.result = (b == 0) ? a : a % b;
            endcase
            e.taken = 1'b0;
        end
        return e;
    endfunction

    function automatic op_t blank();
        op_t op;
        op.pc = 32'h0; op.imm = 32'h0; op.rs1 = 32'h0; op.rs2 = 32'h0;
        op.f3 = 3'd0; op.f7 = 7'd0; op.b_src = 1'b0; op.adr_pc = 1'b0;
        op.br = 1'b0; op.jmp = 1'b0; op.auipc = 1'b0; op.lui = 1'b0; op.md = 1'b0;
        op.wb = 14'($urandom());
        return op;
    endfunction

    function automatic op_t md_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        op_t op = blank();
        op.md = 1'b1; op.f7 = 7'h01; op.f3 = f3; op.rs1 = a; op.rs2 = b;
        return op;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t op = blank();
        op.rs1 = rand_val(); op.rs2 = rand_val(); op.imm = rand_val();
        op.pc = $urandom() & 32'hFFFF_FFFC;
        op.f3 = 3'($urandom_range(0, 7));
        op.b_src = 1'($urandom_range(0, 1));
        op.adr_pc = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0, 1: begin op.md = 1'b1; op.f7 = 7'h01; op.b_src = 1'b0; end
            2: op.br = 1'b1;
            3: op.jmp = 1'b1;
            4: op.auipc = 1'b1;
            5: op.lui = 1'b1;
            default: op.f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        endcase
        return op;
    endfunction

    task automatic apply(input op_t op);
        bus.pc = op.pc; bus.pc_plus_4 = op.pc + 32'd4; bus.imm = op.imm;
        bus.rs1_val = op.rs1; bus.rs2_val = op.rs2; bus.funct3 = op.f3; bus.funct7 = op.f7;
        bus.b_src = op.b_src; bus.adr_a_pc = op.adr_pc; bus.is_branch = op.br;
        bus.is_jump = op.jmp; bus.is_auipc = op.auipc; bus.is_lui = op.lui;
        bus.is_muldiv = op.md; bus.wb_ctrl_in = op.wb;
    endtask

    // Entered and left just after a rising edge.
    task automatic send(input op_t op, output int waited);
        apply(op);
        bus.in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) check_eq("accept_timeout", bus.in_ready, 1);
        else exp_q.push_back(model(op));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic measure(input string tag, input op_t op, input int exp_lat, input int exp_busy);
        int n, nb, bad;
        apply(op);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
        exp_q.push_back(model(op));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0; nb = 0; bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy) nb++;
            if (bus.in_ready && !bus.out_valid) bad++;
        end while (!bus.out_valid && n < 200);
        check_eq({tag, "_latency"}, n, exp_lat);
        check_eq({tag, "_busy_cycles"}, nb, exp_busy);
        check_eq({tag, "_ready_while_busy"}, bad, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic expect_last(input string tag, input logic [31:0] val);
        wait_drain();
        check_eq(tag, last_res, val);
    endtask

    logic        hold_prev = 1'b0;
    logic [31:0] hold_res;
    logic [13:0] hold_wb;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && hold_prev) begin
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_result", bus.result, hold_res);
            check_eq("hold_wb", bus.wb_ctrl_out, hold_wb);
        end
        hold_prev = rst_n && bus.out_valid && !bus.out_ready && !bus.flush;
        hold_res  = bus.result;
        hold_wb   = bus.wb_ctrl_out;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check_eq("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("result", bus.result, e.result);
                check_eq("funct3_out", bus.funct3_out, e.f3);
                check_eq("wb_ctrl_out", bus.wb_ctrl_out, e.wb);
                check_eq("branch_taken", bus.branch_taken, e.taken);
                if (!e.md) begin
                    check_eq("calc_adr", bus.calc_adr, e.calc);
                    check_eq("rs2_out", bus.rs2_out, e.rs2);
                end
            end
            last_res   = bus.result;
            last_calc  = bus.calc_adr;
            last_taken = bus.branch_taken;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_en) bus.out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t op, op2;
        int w, cnt_v;
        apply(blank());
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_result", bus.result, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_wb", bus.wb_ctrl_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op = blank(); op.rs1 = 32'd5; op.rs2 = 32'hFFFF_FFFD;
        measure("add", op, 1, 0);
        expect_last("add_val", 32'd2);

        send(op, w);
        op.f7 = 7'h20; op.rs2 = 32'd7;
        send(op, w);
        check_eq("b2b_stall", w, 0);
        expect_last("sub_val", 32'hFFFF_FFFE);

        op = blank(); op.br = 1'b1; op.f3 = 3'd4; op.rs1 = 32'hFFFF_FFFF; op.rs2 = 32'd1;
        send(op, w); wait_drain(); check_eq("blt_taken", last_taken, 1);
        op.f3 = 3'd6;
        send(op, w); wait_drain(); check_eq("bltu_taken", last_taken, 0);
        op = blank(); op.jmp = 1'b1; op.adr_pc = 1'b1; op.pc = 32'h100; op.imm = 32'h20;
        send(op, w);
        expect_last("jal_result", 32'h104);
        check_eq("jal_calc", last_calc, 32'h120);

        measure("mul", md_op(3'd0, 32'd7, 32'hFFFF_FFFD), XLEN + 2, XLEN);
        expect_last("mul_val", 32'hFFFF_FFEB);
        measure("mulhu", md_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), XLEN + 2, XLEN);
        expect_last("mulhu_val", 32'hFFFF_FFFE);
        send(md_op(3'd4, 32'hFFFF_FFF9, 32'd2), w); expect_last("div_val", 32'hFFFF_FFFD);
        send(md_op(3'd6, 32'hFFFF_FFF9, 32'd2), w); expect_last("rem_val", 32'hFFFF_FFFF);
        measure("divu0", md_op(3'd5, 32'h1234_5678, 32'd0), XLEN + 2, XLEN);
        expect_last("divu0_val", 32'hFFFF_FFFF);
        send(md_op(3'd6, 32'h1234_5678, 32'd0), w); expect_last("rem0_val", 32'h1234_5678);
        send(md_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), w); expect_last("div_ovf", 32'h8000_0000);
        send(md_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), w); expect_last("rem_ovf", 32'h0);

        // Output held under backpressure, then released with a waiting op.
        bus.out_ready = 1'b0;
        op = blank(); op.rs1 = 32'hAAAA_0000; op.rs2 = 32'h0000_5555; op.f3 = 3'd6;
        send(op, w);
        op2 = blank(); op2.rs1 = 32'd9; op2.rs2 = 32'd4;
        apply(op2);
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_in_ready", bus.in_ready, 0);
            check_eq("bp_result", bus.result, 32'hAAAA_5555);
            check_eq("bp_wb", bus.wb_ctrl_out, op.wb);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", bus.in_ready, 1);
        exp_q.push_back(model(op2));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        expect_last("bp_next_val", 32'd13);

        // Flush at iteration 10 of a divide.
        apply(md_op(3'd4, 32'd1000, 32'd7));
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_eq("flush_div_accept", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        apply(op2);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_eq("flush_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_busy", bus.busy, 0);
        check_eq("flush_out_valid", bus.out_valid, 0);
        check_eq("flush_in_ready_after", bus.in_ready, 1);
        cnt_v = 0;
        repeat (XLEN + 5) begin
            @(negedge clk);
            if (bus.out_valid) cnt_v++;
        end
        check_eq("flush_discarded", cnt_v, 0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a multiply.
        apply(md_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_out_valid", bus.out_valid, 0);
        check_eq("arst_result", bus.result, 0);
        check_eq("arst_calc", bus.calc_adr, 0);
        check_eq("arst_wb", bus.wb_ctrl_out, 0);
        check_eq("arst_f3", bus.funct3_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_op(), w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        wait_drain();
        bp_en = 1'b0;
        bus.out_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_execute_unit.md
Name: pipelined_execute_unit

Overview:
- Registered, handshaked successor to the single-cycle execute stage.
- Sits between the decode and memory stages of the pipelined core.
- Executes RV32I/RV64I ALU, branch, jump, AUIPC and LUI operations with 1-cycle latency.
- Adds an iterative M-extension multiply/divide unit that stalls upstream through valid/ready backpressure.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- WB_W, 14, width of the writeback-control passthrough bundle.
- MULDIV_EN, 1, 1 = M-extension present; 0 = is_muldiv ignored, op treated as ALU.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill in-flight and output-held ops (branch redirect).
- in_valid  in  1  decode offers an op.
- in_ready  out  1  unit accepts the op this cycle.
- pc, pc_plus_4, imm, rs1_val, rs2_val  in  XLEN each  operands.
- funct3  in  3  ALU/branch/muldiv sub-op.
- funct7  in  7  bit 5 selects SUB/SRA; bit 0 marks muldiv on R-type.
- b_src  in  1  1 = imm as B, 0 = rs2_val.
- adr_a_pc  in  1  address adder A input: 1 = pc, 0 = rs1_val.
- is_branch, is_jump, is_auipc, is_lui, is_muldiv  in  1 each  op class.
- wb_ctrl_in  in  WB_W  passthrough (rd, rf_we, mem_we, wb_src, ...).
- out_valid  out  1  output register holds a result.
- out_ready  in  1  memory stage consumes.
- result  out  XLEN  ALU / muldiv / pc+4 / pc+imm / imm.
- calc_adr  out  XLEN  address adder output (adr_a ? pc : rs1) + imm.
- rs2_out  out  XLEN  registered rs2_val for stores.
- branch_taken  out  1  condition true AND is_branch.
- funct3_out  out  3  registered funct3.
- wb_ctrl_out  out  WB_W  registered passthrough.
- busy  out  1  muldiv iteration in progress.

Behaviour:
- Reset (async on rst_n low): all outputs 0; FSM to IDLE; counters 0.
- Accept condition: in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
- Non-muldiv op: output register loads on the accepting edge, out_valid=1 next cycle (latency 1).
- Result priority: is_jump → pc_plus_4; is_auipc → calc_adr; is_lui → imm; otherwise ALU(funct3, funct7[5], A=rs1, B=b_src?imm:rs2).
- Shifts use shamt = B[$clog2(XLEN)-1:0].
- Branch condition by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 → 0.
- Muldiv op (MULDIV_EN & is_muldiv): operands, wb_ctrl, funct3 latched on accept; FSM IDLE→MUL (funct3[2]=0) or IDLE→DIV (funct3[2]=1); busy=1.
- MUL state: XLEN shift-add iterations of 2·XLEN product on magnitudes, sign-corrected at end per MUL/MULH/MULHSU/MULHU.
- DIV state: XLEN restoring iterations on magnitudes, signs applied per DIV/DIVU/REM/REMU.
- Counter width $clog2(XLEN)+1. After last iteration → DONE.
- DONE: loads output register, out_valid=1, → IDLE. Accept-to-out_valid latency = XLEN+2 cycles.
- Divide by zero: quotient all-ones; remainder = dividend. Completes in normal latency; no early exit.
- Signed overflow (min-int / -1): quotient = min-int; remainder = 0.
- Backpressure: out_valid & !out_ready holds every output stable; no new accept; DONE waits until the register is free.
- flush: combinational kill. Next edge: out_valid=0; FSM→IDLE; busy=0; in-flight muldiv discarded. An in_valid in the flush cycle is not accepted.
- flush takes priority over accept and DONE on the same edge.
- out_ready with out_valid and a new accept on the same edge: register reloads; out_valid stays 1 (back-to-back throughput 1/cycle for ALU ops).

Test Plan:
- ADD rs1=5, rs2=0xFFFFFFFD, b_src=0, out_ready=1 → out_valid 1 cycle later, result=2. Back-to-back SUB 5-7 → 0xFFFFFFFE next cycle.
- BLT rs1=0xFFFFFFFF, rs2=1, is_branch=1 → branch_taken=1. Same operands as BLTU → 0. JAL pc=0x100, imm=0x20 → result=0x104, calc_adr=0x120.
- MUL 7×0xFFFFFFFD → busy for 32 cycles, out_valid at accept+34, result=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. in_ready=0 throughout.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU x/0 → 0xFFFFFFFF. REM x/0 → x. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Hold out_ready=0 for 5 cycles with a result held → result and wb_ctrl_out stable, in_ready=0. Release → next op accepted same cycle.
- flush at iteration 10 of a DIV → next cycle busy=0, out_valid=0, in_ready=1. rst_n pulsed low mid-MUL → all outputs 0 immediately.
